pixel_neuron_mac: RTL and testbench

Sequencer and multiply-accumulate engine for the first dense layer of the digit classifier. It walks all pixels of the stored image through the grayscale fetch handshake of the image memory controller. Each pixel value is multiplied by a signed weight read from weight memory and accumulated on top of a per-neuron bias. ReLU and saturation are applied, and one 16-bit activation is emitted per neuron to the next layer.

---
 rtl/pixel_neuron_mac.sv | 137 +++++++++++++
 tb/tb_pixel_neuron_mac.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_neuron_mac.sv
// pixel_neuron_mac: first dense layer sequencer and MAC engine.
// Walks every pixel per neuron, accumulates on the bias, emits ReLU'd Q16 activations.
module pixel_neuron_mac #(
  parameter int N_PIXELS  = 784,
  parameter int N_NEURONS = 10,
  parameter int W_ADDR_W  = 13,
  parameter int ACC_W     = 40,
  parameter int FRAC_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [9:0]          pixel_no,
  output logic                grayscale_fetch,
  input  logic                grayscale_fetched,
  input  logic [15:0]         gray_scale,
  output logic [W_ADDR_W-1:0] weight_addr,
  input  logic [15:0]         weight_data,
  output logic [3:0]          bias_addr,
  input  logic [15:0]         bias_data,
  output logic                neuron_valid,
  output logic [3:0]          neuron_idx,
  output logic [15:0]         neuron_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS_ADDR,
    S_BIAS_LOAD,
    S_FETCH,
    S_MAC,
    S_OUT,
    S_DONE
  } state_t;

  localparam logic [9:0] PIX_LAST = 10'(N_PIXELS - 1);
  localparam logic [3:0] NRN_LAST = 4'(N_NEURONS - 1);

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [32:0]       prod;
  logic [15:0]              act;

  assign sum = acc + {{(ACC_W-33){prod[32]}}, prod};

  // Activation is taken from the final sum so neuron_out is ready in OUT.
  always_comb begin
    shifted = sum >>> FRAC_BITS;
    act     = 16'd0;
    if (sum[ACC_W-1])
      act = 16'd0;
    else if (|shifted[ACC_W-1:16])
      act = 16'hFFFF;
    else
      act = shifted[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      acc             <= '0;
      prod            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pixel_no        <= '0;
      grayscale_fetch <= 1'b0;
      weight_addr     <= '0;
      bias_addr       <= '0;
      neuron_valid    <= 1'b0;
      neuron_idx      <= '0;
      neuron_out      <= '0;
    end else begin
      done         <= 1'b0;
      neuron_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            neuron_idx  <= '0;
            bias_addr   <= '0;
            pixel_no    <= '0;
            weight_addr <= '0;
            state       <= S_BIAS_ADDR;
          end
        end
        S_BIAS_ADDR: state <= S_BIAS_LOAD;
        S_BIAS_LOAD: begin
          acc             <= {{(ACC_W-16){bias_data[15]}}, bias_data};
          grayscale_fetch <= 1'b1;
          state           <= S_FETCH;
        end
        S_FETCH: begin
          if (grayscale_fetched) begin
            prod <= $signed({{17{1'b0}}, gray_scale})
                  * $signed({{17{weight_data[15]}}, weight_data});
            grayscale_fetch <= 1'b0;
            state           <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= sum;
          if (pixel_no == PIX_LAST) begin
            neuron_out   <= act;
            neuron_valid <= 1'b1;
            state        <= S_OUT;
          end else begin
            pixel_no        <= pixel_no + 10'd1;
            weight_addr     <= weight_addr + W_ADDR_W'(1);
            grayscale_fetch <= 1'b1;
            state           <= S_FETCH;
          end
        end
        S_OUT: begin
          if (neuron_idx == NRN_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            neuron_idx  <= neuron_idx + 4'd1;
            bias_addr   <= neuron_idx + 4'd1;
            pixel_no    <= '0;
            // Last address of this neuron plus one is the next neuron's base.
            weight_addr <= weight_addr + W_ADDR_W'(1);
            state       <= S_BIAS_ADDR;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_neuron_mac.sv
// tb_pixel_neuron_mac: random and directed runs against a dot-product model.
// Fetch stage latency is variable; memories are 1-cycle synchronous reads.
module tb_pixel_neuron_mac;

  localparam int NP = 32;
  localparam int NN = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [9:0]  pixel_no;
  logic        grayscale_fetch;
  logic        grayscale_fetched;
  logic [15:0] gray_scale;
  logic [12:0] weight_addr;
  logic [15:0] weight_data;
  logic [3:0]  bias_addr;
  logic [15:0] bias_data;
  logic        neuron_valid;
  logic [3:0]  neuron_idx;
  logic [15:0] neuron_out;

  always #5 clk = ~clk;

  pixel_neuron_mac #(
    .N_PIXELS (NP),
    .N_NEURONS(NN)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .pixel_no         (pixel_no),
    .grayscale_fetch  (grayscale_fetch),
    .grayscale_fetched(grayscale_fetched),
    .gray_scale       (gray_scale),
    .weight_addr      (weight_addr),
    .weight_data      (weight_data),
    .bias_addr        (bias_addr),
    .bias_data        (bias_data),
    .neuron_valid     (neuron_valid),
    .neuron_idx       (neuron_idx),
    .neuron_out       (neuron_out)
  );

  logic [15:0] img  [1024];
  logic [15:0] wmem [8192];
  logic [15:0] bmem [16];
  int          lat = 3;
  int          cnt = 0;
  bit          inject = 1'b1;
  longint      expv [NN];
  int          n_chk = 0;
  int          n_fail = 0;

  always @(posedge clk) begin
    weight_data <= wmem[weight_addr];
    bias_data   <= bmem[bias_addr];
  end

  // Fetch stage: pulse L cycles after request rise; junk on the bus otherwise.
  always @(posedge clk) begin
    grayscale_fetched <= 1'b0;
    gray_scale        <= 16'($urandom);
    if (rst || !grayscale_fetch) begin
      cnt <= 0;
      if (inject && !busy) grayscale_fetched <= 1'($urandom);
    end else begin
      cnt <= cnt + 1;
      if (cnt == lat - 1) begin
        grayscale_fetched <= 1'b1;
        gray_scale        <= img[pixel_no];
      end
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model();
    for (int n = 0; n < NN; n++) begin
      longint acc = longint'($signed(bmem[n]));
      for (int p = 0; p < NP; p++)
        acc += longint'(img[p]) * longint'($signed(wmem[n*NP+p]));
      if (acc < 0) expv[n] = 0;
      else if (acc / 256 > 65535) expv[n] = 65535;
      else expv[n] = acc / 256;
    end
  endfunction

  task automatic check_reset(input string nm);
    check({nm, " busy"}, busy, 0);
    check({nm, " done"}, done, 0);
    check({nm, " fetch"}, grayscale_fetch, 0);
    check({nm, " valid"}, neuron_valid, 0);
    check({nm, " pixel_no"}, pixel_no, 0);
    check({nm, " idx"}, neuron_idx, 0);
    check({nm, " waddr"}, weight_addr, 0);
    check({nm, " baddr"}, bias_addr, 0);
    check({nm, " out"}, neuron_out, 0);
  endtask

  task automatic fill_rand();
    for (int p = 0; p < NP; p++) img[p] = 16'($urandom_range(0, 255));
    for (int i = 0; i < NN*NP; i++) wmem[i] = 16'($urandom_range(0, 1023) - 512);
    for (int n = 0; n < NN; n++) bmem[n] = 16'($urandom_range(0, 8191) - 4096);
  endtask

  task automatic run(input int l, input bit noise, input bit hold, input string nm);
    int vt [NN];
    int vcnt = 0, dcyc = -1, hs = 0, berr = 0;
    bit prev_f = 1'b0, prev_acc = 1'b0, busy_done = 1'b1;
    logic [9:0] prev_p = '0;
    logic [12:0] prev_w = '0;
    lat = l;
    model();
    for (int i = 0; i < NN; i++) vt[i] = 0;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < 20000 && dcyc < 0; cyc++) begin
      @(negedge clk);
      if (!hold) start = (noise && busy) ? 1'($urandom) : 1'b0;
      if (!busy && !done) berr++;
      if (grayscale_fetch && prev_f && (pixel_no !== prev_p || weight_addr !== prev_w)) hs++;
      if (grayscale_fetch && weight_addr !== 13'(neuron_idx*NP + pixel_no)) hs++;
      if (prev_acc && grayscale_fetch) hs++;
      if (bias_addr !== neuron_idx) hs++;
      prev_acc = grayscale_fetch && grayscale_fetched;
      prev_f   = grayscale_fetch;
      prev_p   = pixel_no;
      prev_w   = weight_addr;
      if (neuron_valid) begin
        if (vcnt < NN) begin
          check($sformatf("%s idx%0d", nm, vcnt), neuron_idx, vcnt);
          check($sformatf("%s out%0d", nm, vcnt), neuron_out, expv[vcnt]);
          vt[vcnt] = cyc;
        end
        vcnt++;
      end
      if (done) begin
        dcyc = cyc;
        busy_done = busy;
      end
    end
    if (dcyc < 0) begin
      check({nm, " timeout"}, 0, 1);
      return;
    end
    check({nm, " nvalid"}, vcnt, NN);
    check({nm, " done_at"}, dcyc, vt[NN-1] + 1);
    check({nm, " busy@done"}, busy_done, 0);
    for (int i = 1; i < NN; i++)
      check($sformatf("%s period%0d", nm, i), vt[i] - vt[i-1], 3 + NP*(l+2));
    check({nm, " handshake"}, hs, 0);
    check({nm, " busy"}, berr, 0);
  endtask

  initial begin
    bit hit = 1'b0;
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 8192; i++) wmem[i] = '0;
    for (int i = 0; i < 1024; i++) img[i] = '0;
    for (int i = 0; i < 16; i++) bmem[i] = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int p = 0; p < NP; p++) img[p] = 16'd1;
    for (int i = 0; i < NN*NP; i++) wmem[i] = 16'h0100;
    for (int n = 0; n < NN; n++) bmem[n] = 16'h0000;
    run(3, 1'b0, 1'b0, "ones");

    for (int i = 0; i < NN*NP; i++) wmem[i] = 16'h0000;
    for (int n = 0; n < NN; n++) bmem[n] = n[0] ? 16'hFB00 : 16'h0500;
    run(1, 1'b0, 1'b0, "bias");

    for (int p = 0; p < NP; p++) img[p] = 16'd255;
    for (int n = 0; n < NN; n++) begin
      bmem[n] = 16'h0000;
      for (int p = 0; p < NP; p++) wmem[n*NP+p] = n[0] ? 16'h8000 : 16'h7FFF;
    end
    run(7, 1'b0, 1'b0, "sat");

    fill_rand();
    run(1, 1'b1, 1'b0, "rnd_l1");
    run(3, 1'b1, 1'b0, "rnd_l3");
    run(7, 1'b1, 1'b0, "rnd_l7");

    lat = 3;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 5000 && !hit; c++) begin
      @(negedge clk);
      hit = (neuron_idx == 4'd4 && pixel_no == 10'd20);
    end
    check("rst_reach", hit, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    rst = 1'b0;
    @(negedge clk);
    check("post_rst fetch", grayscale_fetch, 0);
    fill_rand();
    run(3, 1'b0, 1'b0, "after_rst");

    fill_rand();
    run(3, 1'b0, 1'b1, "hold1");
    run(3, 1'b1, 1'b0, "hold2");
    repeat (3) @(negedge clk);
    check("idle busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
